// File: rtl/mov_sched_if.sv
// Candidate-position bus between the movement scheduler and the shared
// obstacle-collision checker.
interface mov_sched_if;
  logic [9:0] chk_x;
  logic [8:0] chk_y;
  logic       chk_hit;

  modport master (output chk_x, output chk_y, input chk_hit);
  modport slave  (input chk_x, input chk_y, output chk_hit);
endinterface

// File: rtl/mov_sched.sv
// Per-frame movement scheduler: walks left/right/up/down, presents each in-bounds
// candidate to the shared collision checker and commits the moves it accepts.
module mov_sched #(
  parameter int unsigned STEP    = 2,
  parameter int unsigned X_INI   = 120,
  parameter int unsigned Y_INI   = 130,
  parameter int unsigned H_MAX   = 640,
  parameter int unsigned V_MAX   = 480,
  parameter int unsigned CHK_LAT = 2
) (
  input  logic        VGA_clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic [6:0]  tamanho,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_up,
  input  logic        btn_down,
  mov_sched_if.master chk,
  output logic [9:0]  xPos,
  output logic [8:0]  yPos,
  output logic        busy,
  output logic        done,
  output logic [3:0]  blocked,
  output logic        overrun
);

  localparam int unsigned CntW = $clog2(CHK_LAT + 1);

  typedef enum logic [1:0] {StIdle, StSel, StWait, StDecide} state_e;

  state_e          state_q, state_d;
  logic [1:0]      d_q;
  logic [3:0]      req_q;
  logic [CntW-1:0] cnt_q;
  logic [9:0]      chk_x_q, x_q;
  logic [8:0]      chk_y_q, y_q;
  logic            busy_q, done_q, overrun_q;
  logic [3:0]      blocked_q;

  logic [9:0]  cand_x;
  logic [8:0]  cand_y;
  logic [10:0] x_ext, y_ext;
  logic        oob;
  logic        accept, sel_chk, set_blk, commit, advance;
  logic        lr, ud;
  logic [3:0]  req_new;

  assign x_ext   = {1'b0, x_q};
  assign y_ext   = {2'b0, y_q};
  assign lr      = btn_left & btn_right;
  assign ud      = btn_up & btn_down;
  assign req_new = {btn_down & ~ud, btn_up & ~ud, btn_right & ~lr, btn_left & ~lr};

  // Candidate and bounds test always start from the current committed position,
  // so y candidates already see this frame's x move.
  always_comb begin
    cand_x = x_q;
    cand_y = y_q;
    oob    = 1'b0;
    unique case (d_q)
      2'd0: begin
        cand_x = x_q - 10'(STEP);
        oob    = x_ext < 11'(STEP);
      end
      2'd1: begin
        cand_x = x_q + 10'(STEP);
        oob    = (x_ext + 11'(tamanho) + 11'(STEP)) > 11'(H_MAX);
      end
      2'd2: begin
        cand_y = y_q - 9'(STEP);
        oob    = y_ext < 11'(STEP);
      end
      2'd3: begin
        cand_y = y_q + 9'(STEP);
        oob    = (y_ext + 11'(tamanho) + 11'(STEP)) > 11'(V_MAX);
      end
    endcase
  end

  // State register
  always_ff @(posedge VGA_clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (frame_tick) state_d = StSel;
      StSel: begin
        if (req_q[d_q] && !oob) state_d = StWait;
        else if (d_q == 2'd3)   state_d = StIdle;
      end
      StWait:   if (cnt_q == CntW'(1)) state_d = StDecide;
      StDecide: state_d = (d_q == 2'd3) ? StIdle : StSel;
    endcase
  end

  // Per-state control strobes
  always_comb begin
    accept  = 1'b0;
    sel_chk = 1'b0;
    set_blk = 1'b0;
    commit  = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      StIdle: accept = frame_tick;
      StSel: begin
        sel_chk = req_q[d_q] & ~oob;
        set_blk = req_q[d_q] & oob;
        advance = ~sel_chk;
      end
      StWait: ;
      StDecide: begin
        set_blk = chk.chk_hit;
        commit  = ~chk.chk_hit;
        advance = 1'b1;
      end
    endcase
  end

  always_ff @(posedge VGA_clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q       <= 2'd0;
      req_q     <= 4'd0;
      cnt_q     <= '0;
      chk_x_q   <= 10'(X_INI);
      chk_y_q   <= 9'(Y_INI);
      x_q       <= 10'(X_INI);
      y_q       <= 9'(Y_INI);
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      blocked_q <= 4'd0;
    end else begin
      busy_q    <= (state_d != StIdle);
      done_q    <= advance && (d_q == 2'd3);
      overrun_q <= frame_tick && (state_q != StIdle);
      if (accept) begin
        req_q     <= req_new;
        blocked_q <= 4'd0;
        d_q       <= 2'd0;
      end
      if (sel_chk) begin
        chk_x_q <= cand_x;
        chk_y_q <= cand_y;
        cnt_q   <= CntW'(CHK_LAT);
      end
      if (state_q == StWait) cnt_q <= cnt_q - CntW'(1);
      if (set_blk) blocked_q[d_q] <= 1'b1;
      // The registered candidate differs from the position on one axis only.
      if (commit) begin
        x_q <= chk_x_q;
        y_q <= chk_y_q;
      end
      if (advance && (d_q != 2'd3)) d_q <= d_q + 2'd1;
    end
  end

  assign chk.chk_x = chk_x_q;
  assign chk.chk_y = chk_y_q;
  assign xPos      = x_q;
  assign yPos      = y_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign blocked   = blocked_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_mov_sched.sv
// Directed bench for mov_sched: a wall model acts as the collision checker and a
// scoreboard queue holds the candidates each frame is expected to present.
module tb_mov_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic [6:0] tamanho = 7'd10;
  logic       bl = 1'b0, br = 1'b0, bu = 1'b0, bd = 1'b0;
  logic       wall_en = 1'b0;
  logic       l_left = 1'b0, r_right = 1'b0;

  logic [9:0] xPos, l_xPos, r_xPos;
  logic [8:0] yPos, l_yPos, r_yPos;
  logic       busy, done, overrun;
  logic [3:0] blocked, l_blocked, r_blocked;
  logic       l_busy, l_done, l_ovr, r_busy, r_done, r_ovr;

  int total = 0;
  int bad = 0;
  logic [18:0] sb[$];
  logic [18:0] last;
  int ncyc;

  always #5 clk = ~clk;

  mov_sched_if mif ();
  mov_sched_if lif ();
  mov_sched_if rif ();

  // Wall: everything above y=130 is an obstacle when enabled.
  assign mif.chk_hit = wall_en && (mif.chk_y < 9'd130);
  assign lif.chk_hit = 1'b0;
  assign rif.chk_hit = 1'b0;

  mov_sched dut (
    .VGA_clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .tamanho(tamanho),
    .btn_left(bl), .btn_right(br), .btn_up(bu), .btn_down(bd), .chk(mif),
    .xPos(xPos), .yPos(yPos), .busy(busy), .done(done), .blocked(blocked),
    .overrun(overrun)
  );

  mov_sched #(.X_INI(1)) dut_l (
    .VGA_clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .tamanho(tamanho),
    .btn_left(l_left), .btn_right(1'b0), .btn_up(1'b0), .btn_down(1'b0), .chk(lif),
    .xPos(l_xPos), .yPos(l_yPos), .busy(l_busy), .done(l_done), .blocked(l_blocked),
    .overrun(l_ovr)
  );

  mov_sched #(.X_INI(629)) dut_r (
    .VGA_clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .tamanho(tamanho),
    .btn_left(1'b0), .btn_right(r_right), .btn_up(1'b0), .btn_down(1'b0), .chk(rif),
    .xPos(r_xPos), .yPos(r_yPos), .busy(r_busy), .done(r_done), .blocked(r_blocked),
    .overrun(r_ovr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1 frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
  endtask

  // Follows one evaluation: pops the scoreboard on each new candidate, counts busy
  // cycles, checks the done pulse and that the scoreboard drained.
  task automatic watch(output int n);
    logic [18:0] cur;
    bit fin;
    n = 0;
    fin = 1'b0;
    for (int i = 0; i < 40 && !fin; i++) begin
      @(negedge clk);
      cur = {mif.chk_x, mif.chk_y};
      if (cur != last) begin
        last = cur;
        total++;
        assert (sb.size() != 0)
        else begin
          bad++;
          $error("FAIL cand_unexp: observed=%h expected=none", cur);
        end
        if (sb.size() != 0) check("cand", 32'(cur), 32'(sb.pop_front()));
      end
      if (busy) n++;
      else begin
        fin = 1'b1;
        check("done_pulse", 32'(done), 32'd1);
      end
    end
    if (!fin) begin
      total++;
      bad++;
      $display("FAIL frame_timeout: observed=busy expected=idle within 40 cycles");
    end
    @(negedge clk);
    check("done_low", 32'(done), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    last = {10'd120, 9'd130};
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_x", 32'(xPos), 32'd120);
    check("rst_y", 32'(yPos), 32'd130);
    check("rst_chk", 32'({mif.chk_x, mif.chk_y}), 32'({10'd120, 9'd130}));
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_blk", 32'(blocked), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);

    // No keys: four idle directions, nothing presented.
    tick();
    watch(ncyc);
    check("nokey_busy", 32'(ncyc), 32'd4);
    check("nokey_pos", 32'({xPos, yPos}), 32'({10'd120, 9'd130}));
    check("nokey_blk", 32'(blocked), 32'd0);

    // Right + down, open floor.
    br = 1'b1; bd = 1'b1;
    sb.push_back({10'd122, 9'd130});
    sb.push_back({10'd122, 9'd132});
    tick();
    br = 1'b0; bd = 1'b0;
    watch(ncyc);
    check("rd_busy", 32'(ncyc), 32'd10);
    check("rd_pos", 32'({xPos, yPos}), 32'({10'd122, 9'd132}));
    check("rd_blk", 32'(blocked), 32'd0);

    // Opposing keys cancel.
    bl = 1'b1; br = 1'b1;
    tick();
    bl = 1'b0; br = 1'b0;
    watch(ncyc);
    check("lr_busy", 32'(ncyc), 32'd4);
    check("lr_pos", 32'({xPos, yPos}), 32'({10'd122, 9'd132}));
    check("lr_blk", 32'(blocked), 32'd0);

    // Reset while waiting on the checker for a right move.
    br = 1'b1;
    tick();
    br = 1'b0;
    repeat (3) @(negedge clk);
    check("wait_chk", 32'(mif.chk_x), 32'd124);
    check("wait_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_pos", 32'({xPos, yPos}), 32'({10'd120, 9'd130}));
    check("arst_chk", 32'({mif.chk_x, mif.chk_y}), 32'({10'd120, 9'd130}));
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_blk", 32'(blocked), 32'd0);
    last = {10'd120, 9'd130};
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Up into the wall: refused, position kept.
    wall_en = 1'b1;
    bu = 1'b1;
    sb.push_back({10'd120, 9'd128});
    tick();
    bu = 1'b0;
    watch(ncyc);
    check("up_busy", 32'(ncyc), 32'd7);
    check("up_pos", 32'({xPos, yPos}), 32'({10'd120, 9'd130}));
    check("up_blk", 32'(blocked), 32'b0100);

    // Left + up: x moves, then y candidate uses the new x and hits the wall.
    bl = 1'b1; bu = 1'b1;
    sb.push_back({10'd118, 9'd130});
    sb.push_back({10'd118, 9'd128});
    tick();
    bl = 1'b0; bu = 1'b0;
    watch(ncyc);
    check("diag_busy", 32'(ncyc), 32'd10);
    check("diag_pos", 32'({xPos, yPos}), 32'({10'd118, 9'd130}));
    check("diag_blk", 32'(blocked), 32'b0100);
    wall_en = 1'b0;

    // Screen-edge refusals on the boundary instances.
    l_left = 1'b1; r_right = 1'b1;
    tick();
    l_left = 1'b0; r_right = 1'b0;
    watch(ncyc);
    check("bl_blk", 32'(l_blocked), 32'b0001);
    check("bl_chk", 32'(lif.chk_x), 32'd1);
    check("bl_x", 32'(l_xPos), 32'd1);
    check("br_blk", 32'(r_blocked), 32'b0010);
    check("br_x", 32'(r_xPos), 32'd629);
    check("br_chk", 32'(rif.chk_x), 32'd629);
    check("br_busy", 32'(r_busy), 32'd0);

    // Tick while busy: single overrun pulse, evaluation unaffected.
    tick();
    @(posedge clk);
    #1 frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
    @(negedge clk);
    check("ovr_hi", 32'(overrun), 32'd1);
    check("ovr_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("ovr_lo", 32'(overrun), 32'd0);
    ncyc = 0;
    for (int i = 0; i < 20 && busy; i++) begin
      @(negedge clk);
      ncyc++;
    end
    check("ovr_tail", 32'(ncyc), 32'd1);
    check("ovr_done", 32'(done), 32'd1);
    @(negedge clk);
    check("ovr_idle", 32'(busy), 32'd0);
    check("ovr_pos", 32'({xPos, yPos}), 32'({10'd118, 9'd130}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
